fifo_drain_sched: RTL

- Read-side scheduler for the ten 8-bit codestream FIFOs that the BPC/MQ write stage fills in rotating order.
- Drains the FIFOs in the same ring order (0→9→0) to rebuild one serial, in-order byte stream for the packet/codestream stage.
- Sequences each codeblock: start, drain, flush-on-end and done reporting with a byte count.
- Applies backpressure through a 2-entry output skid buffer.

---
 rtl/fifo_drain_sched.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/fifo_drain_sched.sv
// Read-side scheduler for the ring of codestream byte FIFOs. Drains the
// FIFOs in ring order into one ordered byte stream through a 2-entry skid
// buffer, and sequences codeblock start / flush / done with a byte count.
module fifo_drain_sched #(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned NUM_FIFO = 10
) (
    input  logic                  clk_dwt,
    input  logic                  rst,
    input  logic                  rst_syn,
    input  logic                  cb_start,
    input  logic                  cb_end,
    input  logic [NUM_FIFO-1:0]   rdempty,
    input  logic [8*NUM_FIFO-1:0] fifo_dout,
    output logic [NUM_FIFO-1:0]   rd_req,
    output logic [7:0]            byte_out,
    output logic                  byte_vld,
    input  logic                  byte_rdy,
    output logic                  cb_done,
    output logic [CNT_W-1:0]      cb_bytes,
    output logic                  busy
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned PTR_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   rd_idx_q, rd_idx_d;
    logic               inflight_q, inflight_d;
    logic               end_pend_q, end_pend_d;
    logic [BYTE_W-1:0]  skid0_q, skid0_d;
    logic [BYTE_W-1:0]  skid1_q, skid1_d;
    logic               vld0_q, vld0_d;
    logic               vld1_q, vld1_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               cb_done_q, cb_done_d;
    logic [CNT_W-1:0]   cb_bytes_q, cb_bytes_d;
    logic               busy_q, busy_d;

    logic [BYTE_W-1:0]  push_data;
    logic               pop;
    logic               issue;
    logic               head_empty;
    logic [2:0]         pending;

    assign byte_out = skid0_q;
    assign byte_vld = vld0_q;
    assign cb_done  = cb_done_q;
    assign cb_bytes = cb_bytes_q;
    assign busy     = busy_q;

    // Select the byte returned by the FIFO that was read last cycle.
    always_comb begin
        push_data = '0;
        for (int k = 0; k < NUM_FIFO; k++) begin
            if (rd_idx_q == PTR_W'(k)) begin
                push_data = fifo_dout[BYTE_W*k +: BYTE_W];
            end
        end
    end

    // Read issue: only the FIFO at ptr, only while the skid buffer has room
    // for everything already committed (buffered + in flight - leaving now).
    always_comb begin
        pop        = vld0_q & byte_rdy;
        head_empty = rdempty[ptr_q];
        pending    = 3'(vld0_q) + 3'(vld1_q) + 3'(inflight_q);
        issue      = ((state_q == RUN) || (state_q == FLUSH)) && !head_empty
                     && !rst_syn && (pending < (3'd2 + 3'(pop)));
        rd_req     = issue ? (NUM_FIFO'(1) << ptr_q) : '0;
    end

    // Next-state, pointer, skid buffer and counter logic.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        rd_idx_d   = rd_idx_q;
        inflight_d = issue;
        end_pend_d = end_pend_q;
        skid0_d    = skid0_q;
        skid1_d    = skid1_q;
        vld0_d     = vld0_q;
        vld1_d     = vld1_q;
        count_d    = count_q;
        cb_done_d  = 1'b0;
        cb_bytes_d = cb_bytes_q;

        if (issue) begin
            rd_idx_d = ptr_q;
            ptr_d    = (ptr_q == PTR_W'(NUM_FIFO - 1)) ? '0 : ptr_q + PTR_W'(1);
        end

        // Skid buffer: head in entry 0, returned data appended at the tail.
        case ({inflight_q, pop})
            2'b10: begin
                if (!vld0_q) begin
                    skid0_d = push_data;
                    vld0_d  = 1'b1;
                end else begin
                    skid1_d = push_data;
                    vld1_d  = 1'b1;
                end
            end
            2'b01: begin
                skid0_d = skid1_q;
                vld0_d  = vld1_q;
                vld1_d  = 1'b0;
            end
            2'b11: begin
                if (vld1_q) begin
                    skid0_d = skid1_q;
                    skid1_d = push_data;
                end else begin
                    skid0_d = push_data;
                end
            end
            default: ;
        endcase

        if (pop && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (cb_start) begin
                    state_d    = RUN;
                    ptr_d      = '0;
                    count_d    = '0;
                    cb_bytes_d = '0;
                    end_pend_d = cb_end;
                end
            end
            RUN: begin
                if (cb_end || end_pend_q) begin
                    state_d    = FLUSH;
                    end_pend_d = 1'b0;
                end
            end
            FLUSH: begin
                if (head_empty && !inflight_q && !vld0_q && !vld1_q) begin
                    state_d    = DONE;
                    cb_done_d  = 1'b1;
                    cb_bytes_d = count_q;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN) || (state_d == FLUSH);

        // Synchronous clear: drop everything, including a read in flight.
        if (rst_syn) begin
            state_d    = IDLE;
            ptr_d      = '0;
            rd_idx_d   = '0;
            inflight_d = 1'b0;
            end_pend_d = 1'b0;
            skid0_d    = '0;
            skid1_d    = '0;
            vld0_d     = 1'b0;
            vld1_d     = 1'b0;
            count_d    = '0;
            cb_done_d  = 1'b0;
            cb_bytes_d = '0;
            busy_d     = 1'b0;
        end
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk_dwt or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            rd_idx_q   <= '0;
            inflight_q <= 1'b0;
            end_pend_q <= 1'b0;
            skid0_q    <= '0;
            skid1_q    <= '0;
            vld0_q     <= 1'b0;
            vld1_q     <= 1'b0;
            count_q    <= '0;
            cb_done_q  <= 1'b0;
            cb_bytes_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            rd_idx_q   <= rd_idx_d;
            inflight_q <= inflight_d;
            end_pend_q <= end_pend_d;
            skid0_q    <= skid0_d;
            skid1_q    <= skid1_d;
            vld0_q     <= vld0_d;
            vld1_q     <= vld1_d;
            count_q    <= count_d;
            cb_done_q  <= cb_done_d;
            cb_bytes_q <= cb_bytes_d;
            busy_q     <= busy_d;
        end
    end

endmodule
